thresh_report_tx: RTL and testbench
===================================

// Module: thresh_report_tx
// PURPOSE
//  Reports the key-set Sobel threshold to the host, the read-back end of the threshold path.
//  Watches the 20-bit threshold from the key/display block and emits a fixed-format frame.
//  Frame goes onto a byte stream feeding the UDP TX FIFO; host sees every change and can poll on demand.
//  One frame per trigger; triggers arriving while busy coalesce into one follow-up frame.
// PARAMETERS
//  VAL_W      20     threshold width; fixed at 20, bits [19:16] go in one byte, upper nibble zero
//  SYNC_BYTE  8'hA5  first byte of every frame
//  CMD_ID     8'h01  frame type id for "threshold report"
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous reset, active-low
//  value     in   20  current threshold, synchronous to clk
//  req       in   1   single-cycle host poll request
//  tx_data   out  8   frame byte
//  tx_valid  out  1   tx_data valid
//  tx_ready  in   1   downstream accepts byte when tx_valid&tx_ready
//  tx_last   out  1   high with the final frame byte
//  busy      out  1   high from first byte valid until last byte accepted
// BEHAVIOUR
//  Reset: tx_data=0, tx_valid=0, tx_last=0, busy=0, value_q=0, pending=0, state=IDLE; applies mid-frame, frame abandoned.
//  Change detect: value_q <= value each cycle; value!=value_q or req=1 at an edge sets pending.
//   Since value_q resets to 0, a nonzero post-reset value yields exactly one startup frame.
//  FSM IDLE: if pending -> snap<=value, pending<=0, tx_valid<=1 with byte0, go SEND. tx_valid rises 1 cycle after pending.
//  FSM SEND: byte index advances only on tx_valid&tx_ready; tx_data/tx_last held stable while stalled.
//   On accept of last byte: tx_valid<=0, busy<=0, go IDLE; pending set meanwhile -> new frame after 1 IDLE cycle.
//  Frame: A5, CMD_ID, {4'h0,snap[19:16]}, snap[15:8], snap[7:0], CHK. CHK = XOR of bytes 1..last payload (SYNC excluded).
//  snap frozen for whole frame; value changes mid-frame only set pending (last value wins, no queue).
//  Simultaneous req and change: one pending, one frame. req while pending already set: no extra frame.
//  tx_ready high continuously: one byte per cycle, 6-cycle frame.
// CONFIGURATION
//  THRESH_REPORT_SEQ_EN defined: 8-bit seq byte inserted after CMD_ID, frame 7 bytes; seq resets to 0,
//   increments by 1 (wraps FF->00) on accept of each tx_last; seq included in CHK.
//  Undefined: 6-byte frame as above, no seq counter instantiated.
// STRUCTURE
//  Shared package/include seg_key_pkg: SYNC/CMD constants, frame length constants (6 / 7), byte index width.
//  One natural sub-module: thresh_chg_det (value_q register, req OR change -> pending set pulse).
//  Byte mux + checksum accumulator + FSM stay in this module.
// TESTING
//  After reset, value=127, tx_ready=1 -> bytes A5 01 00 00 7F 7E, tx_last on 7E, then idle.
//  value 127->131, tx_ready=1 -> A5 01 00 00 83 82; tx_valid 1 cycle after pending; no second frame.
//  tx_ready low 3 cycles at byte 3 -> tx_data=00 stable, tx_valid high throughout; frame completes intact.
//  value 131->135 during byte 2 -> current frame carries 83/82; next frame A5 01 00 00 87 86.
//  req pulse in IDLE with value=255 -> A5 01 00 00 FF FE; req+change same cycle -> exactly one frame.
//  rst_n low mid-frame -> tx_valid=0, busy=0 immediately; with SEQ_EN two frames carry seq 00 then 01.

Source files
------------

// File: rtl/seg_key_pkg.sv
// Shared constants for the threshold read-back path: frame bytes, frame lengths, byte index width.
package seg_key_pkg;

  localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
  localparam logic [7:0] CMD_THRESH     = 8'h01;

  localparam int         FRAME_LEN_BASE = 6;
  localparam int         FRAME_LEN_SEQ  = 7;
  localparam int         IDX_W          = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/thresh_chg_det.sv
// Threshold change detector: registers the last seen value and flags a report whenever the
// value moves or the host polls.
module thresh_chg_det
  import seg_key_pkg::*;
#(
  parameter int VAL_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] i_value,
  input  logic             i_req,
  output logic             o_set
);

  logic [VAL_W-1:0] r_value_q;

  // Reset to zero so any nonzero threshold after reset produces one startup report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value_q <= '0;
    end else begin
      r_value_q <= i_value;
    end
  end

  assign o_set = i_req | (i_value != r_value_q);

endmodule

// File: rtl/thresh_report_tx.sv
// Threshold report transmitter: frames the 20-bit threshold as SYNC, CMD, [seq], hi, mid, lo, CHK.
// Optional THRESH_REPORT_SEQ_EN inserts a wrapping sequence byte after CMD.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no frame in flight; a pending trigger snapshots value and starts one
//   ST_SEND | frame bytes presented one at a time, advancing on valid & ready
module thresh_report_tx
  import seg_key_pkg::*;
#(
  parameter int         VAL_W     = 20,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter logic [7:0] CMD_ID    = CMD_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] value,
  input  logic             req,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy
);

`ifdef THRESH_REPORT_SEQ_EN
  localparam int FRAME_LEN = FRAME_LEN_SEQ;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tx_state_e        r_state,   w_state_nxt;
  logic [IDX_W-1:0] r_idx,     w_idx_nxt;
  logic [7:0]       r_tx_data, w_data_nxt;
  logic             r_tx_valid, w_valid_nxt;
  logic             r_tx_last, w_last_nxt;
  logic             r_busy,    w_busy_nxt;
  logic [VAL_W-1:0] r_snap,    w_snap_nxt;
  logic [7:0]       r_chk,     w_chk_nxt;
  logic             r_pending, w_pending_nxt;

  logic             w_set;
  logic             w_accept;
  logic [IDX_W-1:0] w_idx_inc;
  logic [7:0]       w_chk_acc;
  logic [7:0]       w_byte;

  thresh_chg_det #(
    .VAL_W (VAL_W)
  ) u_chg_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_value (value),
    .i_req   (req),
    .o_set   (w_set)
  );

  assign w_accept  = r_tx_valid & tx_ready;
  assign w_idx_inc = r_idx + IDX_W'(1);
  // Running XOR including the byte being accepted now; the sync byte never contributes.
  assign w_chk_acc = r_chk ^ ((r_idx == '0) ? 8'h00 : r_tx_data);

`ifdef THRESH_REPORT_SEQ_EN
  logic [7:0] r_seq;
  logic       w_seq_inc;

  assign w_seq_inc = w_accept & r_tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 8'h00;
    end else if (w_seq_inc) begin
      r_seq <= r_seq + 8'h01;
    end
  end
`endif

  always_comb begin
    w_byte = SYNC_BYTE;
    case (w_idx_inc)
      IDX_W'(1): w_byte = CMD_ID;
`ifdef THRESH_REPORT_SEQ_EN
      IDX_W'(2): w_byte = r_seq;
      IDX_W'(3): w_byte = {4'h0, r_snap[19:16]};
      IDX_W'(4): w_byte = r_snap[15:8];
      IDX_W'(5): w_byte = r_snap[7:0];
      IDX_W'(6): w_byte = w_chk_acc;
`else
      IDX_W'(2): w_byte = {4'h0, r_snap[19:16]};
      IDX_W'(3): w_byte = r_snap[15:8];
      IDX_W'(4): w_byte = r_snap[7:0];
      IDX_W'(5): w_byte = w_chk_acc;
`endif
      default:   w_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_data_nxt    = r_tx_data;
    w_valid_nxt   = r_tx_valid;
    w_last_nxt    = r_tx_last;
    w_busy_nxt    = r_busy;
    w_snap_nxt    = r_snap;
    w_chk_nxt     = r_chk;
    w_pending_nxt = r_pending | w_set;
    case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          // A trigger landing on the snapshot cycle stays pending rather than being lost.
          w_pending_nxt = w_set;
          w_snap_nxt    = value;
          w_idx_nxt     = '0;
          w_data_nxt    = SYNC_BYTE;
          w_valid_nxt   = 1'b1;
          w_last_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
          w_chk_nxt     = 8'h00;
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          if (r_tx_last) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_data_nxt  = 8'h00;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_chk_nxt  = w_chk_acc;
            w_data_nxt = w_byte;
            w_last_nxt = (w_idx_inc == LAST_IDX);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_snap     <= '0;
      r_chk      <= 8'h00;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_data  <= w_data_nxt;
      r_tx_valid <= w_valid_nxt;
      r_tx_last  <= w_last_nxt;
      r_busy     <= w_busy_nxt;
      r_snap     <= w_snap_nxt;
      r_chk      <= w_chk_nxt;
      r_pending  <= w_pending_nxt;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign busy     = r_busy;

endmodule

// File: tb/tb_thresh_report_tx.sv
// Bench for thresh_report_tx: vector table of threshold changes/polls plus hand-timed
// stall, mid-frame change and mid-frame reset sequences. Honours THRESH_REPORT_SEQ_EN.
module tb_thresh_report_tx;
  import seg_key_pkg::*;

`ifdef THRESH_REPORT_SEQ_EN
  localparam int FLEN = FRAME_LEN_SEQ;
`else
  localparam int FLEN = FRAME_LEN_BASE;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] value;
  logic        req;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        busy;

  int          n_checks = 0;
  int          n_errs   = 0;

  logic [7:0]  q_b[$];
  logic        q_l[$];
  logic [7:0]  e_b[$];
  logic [7:0]  e_seq;

  typedef struct {
    logic [19:0] val;
    logic        rq;
    logic [7:0]  hi;
    logic [7:0]  mid;
    logic [7:0]  lo;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  thresh_report_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .req      (req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy)
  );

  // Records every accepted byte, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      q_b.push_back(tx_data);
      q_l.push_back(tx_last);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_frame(input logic [7:0] hi, input logic [7:0] mid,
                           input logic [7:0] lo, input logic [7:0] chk);
    logic [7:0] c;
    c = chk;
    e_b.push_back(8'hA5);
    e_b.push_back(8'h01);
`ifdef THRESH_REPORT_SEQ_EN
    e_b.push_back(e_seq);
    c = c ^ e_seq;
    e_seq = e_seq + 8'h01;
`endif
    e_b.push_back(hi);
    e_b.push_back(mid);
    e_b.push_back(lo);
    e_b.push_back(c);
  endtask

  task automatic compare_frames(input string name);
    check({name, " len"}, 32'(q_b.size()), 32'(e_b.size()));
    for (int i = 0; i < e_b.size() && i < q_b.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), 32'(q_b[i]), 32'(e_b[i]));
      check($sformatf("%s last%0d", name, i), 32'(q_l[i]), 32'((i % FLEN) == FLEN - 1));
    end
    q_b.delete();
    q_l.delete();
    e_b.delete();
  endtask

  task automatic check_idle(input string name);
    check({name, " idle busy"},  32'(busy),     32'd0);
    check({name, " idle valid"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{20'd131,    1'b0, 8'h00, 8'h00, 8'h83, 8'h82};
    vecs[1] = '{20'd255,    1'b0, 8'h00, 8'h00, 8'hFF, 8'hFE};
    vecs[2] = '{20'd255,    1'b1, 8'h00, 8'h00, 8'hFF, 8'hFE};
    vecs[3] = '{20'hABCDE,  1'b1, 8'h0A, 8'hBC, 8'hDE, 8'h69};
    vecs[4] = '{20'hF0001,  1'b0, 8'h0F, 8'h00, 8'h01, 8'h0F};
    vecs[5] = '{20'h00000,  1'b0, 8'h00, 8'h00, 8'h00, 8'h01};

    rst_n = 1'b0; value = 20'd127; req = 1'b0; tx_ready = 1'b1; e_seq = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_valid", 32'(tx_valid), 32'd0);
    check("reset tx_last",  32'(tx_last),  32'd0);
    check("reset busy",     32'(busy),     32'd0);
    check("reset tx_data",  32'(tx_data),  32'd0);
    rst_n = 1'b1;

    repeat (12) @(posedge clk);
    @(negedge clk);
    add_frame(8'h00, 8'h00, 8'h7F, 8'h7E);
    compare_frames("startup");
    check_idle("startup");

    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      value = vecs[k].val;
      req   = vecs[k].rq;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d valid before", k), 32'(tx_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d valid rise", k), 32'(tx_valid), 32'd1);
      check($sformatf("vec%0d first byte", k), 32'(tx_data),  32'hA5);
      check($sformatf("vec%0d busy", k),       32'(busy),     32'd1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      add_frame(vecs[k].hi, vecs[k].mid, vecs[k].lo, vecs[k].chk);
      compare_frames($sformatf("vec%0d", k));
      check_idle($sformatf("vec%0d", k));
    end

    // Backpressure: hold tx_ready low for 3 cycles while byte 3 is presented.
    @(posedge clk); #1;
    value = 20'd131;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("stall valid rise", 32'(tx_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1 tx_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d data", s),  32'(tx_data),  32'h00);
      check($sformatf("stall%0d valid", s), 32'(tx_valid), 32'd1);
      check($sformatf("stall%0d last", s),  32'(tx_last),  32'd0);
      @(posedge clk);
    end
    #1 tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    add_frame(8'h00, 8'h00, 8'h83, 8'h82);
    compare_frames("stall");
    check_idle("stall");

    // Value change during byte 2: current frame keeps 131, one follow-up frame with 135.
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1 value = 20'd135;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midchg gap valid", 32'(tx_valid), 32'd0);
    check("midchg gap busy",  32'(busy),     32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midchg second valid", 32'(tx_valid), 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    add_frame(8'h00, 8'h00, 8'h83, 8'h82);
    add_frame(8'h00, 8'h00, 8'h87, 8'h86);
    compare_frames("midchg");
    check_idle("midchg");

    // Reset mid-frame: outputs drop at once, frame abandoned, startup report after release.
    @(posedge clk); #1;
    value = 20'h00100;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst tx_valid", 32'(tx_valid), 32'd0);
    check("midrst busy",     32'(busy),     32'd0);
    check("midrst tx_last",  32'(tx_last),  32'd0);
    check("midrst tx_data",  32'(tx_data),  32'd0);
    q_b.delete();
    q_l.delete();
    e_b.delete();
    e_seq = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    add_frame(8'h00, 8'h01, 8'h00, 8'h00);
    compare_frames("postrst1");
    @(posedge clk); #1;
    value = 20'h00101;
    repeat (12) @(posedge clk);
    @(negedge clk);
    add_frame(8'h00, 8'h01, 8'h01, 8'h01);
    compare_frames("postrst2");
    check_idle("postrst2");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
